// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch stage with one outstanding imem read, a one-word
//           skid buffer for decode backpressure, and a stop-on-branch policy.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  run_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_valid_i,
    input  logic [31:0]           imem_data_i,
    input  logic                  branch_resolved_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic                  enable_o,
    output logic                  isBranch_o,
    output logic                  instructionFormat_o,
    output logic [6:0]            opcode_o,
    output logic [4:0]            primOperand_o,
    output logic [15:0]           secOperand_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_BR_WAIT = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_pc_one = ADDR_WIDTH'(1);

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   pc_q,       pc_d;
    logic [29:0]             skid_q,     skid_d;
    logic                    req_q,      req_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic                    enable_q,   enable_d;
    logic                    is_branch_q, is_branch_d;
    logic                    format_q,   format_d;
    logic [6:0]              opcode_q,   opcode_d;
    logic [4:0]              prim_q,     prim_d;
    logic [15:0]             sec_q,      sec_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q,   pc_out_d;

    // Bits [17:16] are reserved; the word is kept compacted to 30 bits.
    logic [29:0]             mem_word;
    logic                    unused_reserved;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic                    emit;
    logic [29:0]             emit_word;
    logic                    go;

    assign mem_word        = {imem_data_i[31:18], imem_data_i[15:0]};
    assign unused_reserved = ^imem_data_i[17:16];
    assign pc_inc          = pc_q + c_pc_one;
    assign go              = run_i && !stall_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        skid_d      = skid_q;
        req_d       = 1'b0;
        addr_d      = addr_q;
        enable_d    = 1'b0;
        is_branch_d = is_branch_q;
        format_d    = format_q;
        opcode_d    = opcode_q;
        prim_d      = prim_q;
        sec_d       = sec_q;
        pc_out_d    = pc_out_q;
        emit        = 1'b0;
        emit_word   = mem_word;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid_i) begin
                    if (!stall_i) begin
                        emit = 1'b1;
                    end else begin
                        skid_d  = mem_word;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    emit      = 1'b1;
                    emit_word = skid_q;
                end
            end
            S_BR_WAIT: begin
                if (branch_resolved_i) begin
                    pc_d    = branch_taken_i ? branch_target_i : pc_inc;
                    state_d = go ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (emit) begin
            enable_d    = 1'b1;
            is_branch_d = emit_word[29];
            format_d    = emit_word[28];
            opcode_d    = emit_word[27:21];
            prim_d      = emit_word[20:16];
            sec_d       = emit_word[15:0];
            pc_out_d    = pc_q;
            // Decode cannot flush, so a branch parks fetch until execute resolves it.
            if (emit_word[29]) begin
                state_d = S_BR_WAIT;
            end else begin
                pc_d    = pc_inc;
                state_d = go ? S_REQ : S_IDLE;
            end
        end

        if (state_d == S_REQ) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            skid_q      <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            enable_q    <= 1'b0;
            is_branch_q <= 1'b0;
            format_q    <= 1'b0;
            opcode_q    <= '0;
            prim_q      <= '0;
            sec_q       <= '0;
            pc_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            skid_q      <= skid_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            enable_q    <= enable_d;
            is_branch_q <= is_branch_d;
            format_q    <= format_d;
            opcode_q    <= opcode_d;
            prim_q      <= prim_d;
            sec_q       <= sec_d;
            pc_out_q    <= pc_out_d;
        end
    end

    assign imem_req_o          = req_q;
    assign imem_addr_o         = addr_q;
    assign enable_o            = enable_q;
    assign isBranch_o          = is_branch_q;
    assign instructionFormat_o = format_q;
    assign opcode_o            = opcode_q;
    assign primOperand_o       = prim_q;
    assign secOperand_o        = sec_q;
    assign pc_o                = pc_out_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end instruction fetch stage. Holds the PC, issues one instruction-memory read at a time and splits each returned 32-bit word into the fields the decode stage consumes: isBranch, instructionFormat, opcode, primOperand, secOperand.
- Decode has no branch or hazard handling. This block therefore never fetches past a branch until execute resolves it.
- Owns backpressure (stall_i) toward decode.

Parameters:
- ADDR_WIDTH, 16, width of PC and imem address (word-addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- run_i  in  1  fetch enable; low means finish the outstanding fetch, then idle.
- stall_i  in  1  downstream cannot accept an instruction this cycle.
- imem_req_o  out  1  one-cycle read request strobe.
- imem_addr_o  out  ADDR_WIDTH  read address, valid when imem_req_o=1.
- imem_valid_i  in  1  read data valid, arbitrary latency ≥1.
- imem_data_i  in  32  instruction word.
- branch_resolved_i  in  1  execute has resolved the pending branch.
- branch_taken_i  in  1  qualifies branch_resolved_i.
- branch_target_i  in  ADDR_WIDTH  target PC when taken.
- enable_o  out  1  instruction fields valid (one-cycle pulse per instruction).
- isBranch_o  out  1  word[31].
- instructionFormat_o  out  1  word[30]; 1 = register-immediate.
- opcode_o  out  7  word[29:23].
- primOperand_o  out  5  word[22:18].
- secOperand_o  out  16  word[15:0]; word[17:16] reserved, ignored.
- pc_o  out  ADDR_WIDTH  PC of the delivered instruction.

Behaviour:
- Reset: PC=RESET_PC, state IDLE, skid buffer empty. All outputs 0, including enable_o and imem_req_o.
- States: IDLE, REQ, WAIT, HOLD, BR_WAIT.
- IDLE:
  - imem_req_o=0.
  - run_i=1 and stall_i=0 → REQ.
- REQ:
  - imem_req_o=1, imem_addr_o=PC for exactly this cycle.
  - Always → WAIT.
- WAIT:
  - imem_req_o=0. Wait for imem_valid_i.
  - On valid with stall_i=0: register all fields and pc_o=PC; enable_o=1 the next cycle. Then apply the next-state rule.
  - On valid with stall_i=1: capture word into skid register → HOLD.
- HOLD:
  - enable_o=0 and no requests while stall_i=1.
  - First cycle with stall_i=0: emit the skid word as above, then apply the next-state rule.
- Next-state rule after emitting:
  - isBranch=1 → BR_WAIT, PC unchanged.
  - Otherwise PC=PC+1, modulo 2^ADDR_WIDTH (wraps to 0). Then → REQ if run_i=1 and stall_i=0, else IDLE.
- BR_WAIT:
  - No requests.
  - On branch_resolved_i: PC=branch_target_i if branch_taken_i, else PC+1 (wrapping). Then → REQ if run_i and !stall_i, else IDLE.
- Output holding:
  - enable_o is high exactly one cycle per delivered instruction and is 0 in all other cycles.
  - Field outputs and pc_o hold their last value between deliveries.
- Ignored inputs:
  - branch_resolved_i is ignored outside BR_WAIT.
  - imem_valid_i is ignored outside WAIT, including stale responses after reset.
- At most one outstanding imem request. Throughput ≤1 instruction per (memory latency+2) cycles.
- run_i falling during WAIT/HOLD/BR_WAIT: that operation completes normally, then → IDLE.
- reset_i has priority over every event in the same cycle. Mid-operation it drops the in-flight fetch and the skid contents.

Test Plan:
- Basic fetch:
  - Stimulus: reset, RESET_PC=0, run_i=1; imem returns 0x408C0005 two cycles after req.
  - Required: req at addr 0. One-cycle enable_o with isBranch=0, format=1, opcode=1, prim=3, sec=0x0005, pc_o=0. Next req at addr 1.
- Taken branch:
  - Stimulus: word 0xC4080010 at PC 4; branch_resolved_i=1 with taken=1 and target 0x0040 after 5 cycles.
  - Required: enable_o with isBranch=1, opcode=8, prim=2, sec=0x0010. No imem_req_o during the wait. Next req addr 0x0040.
- Not-taken branch:
  - Stimulus: same branch word at PC 5; resolve with taken=0.
  - Required: next req addr 6. A spurious branch_resolved_i pulse during WAIT has no effect.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles covering imem_valid_i for PC 0x10.
  - Required: enable_o=0 and no req for those cycles. Word delivered the first cycle after stall drops, with pc_o=0x10. Next req addr 0x11.
- Wrap:
  - Stimulus: RESET_PC=0xFFFF, non-branch word.
  - Required: delivered with pc_o=0xFFFF; next req addr 0x0000.
- Reset mid-fetch:
  - Stimulus: reset_i pulsed in WAIT, stale imem_valid_i arrives one cycle later.
  - Required: enable_o stays 0; next req addr RESET_PC.
